wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 32x64 register file; owns its single write port.
- Merges two result sources:
  - the single-cycle ALU path, which never stalls and always has priority;
  - the multi-cycle load/mul path, which uses a valid/ready handshake and is buffered in a small FIFO.
- Drives the register-file write port from registered outputs.
- Exposes pending-destination lookups so decode can stall on RAW hazards against buffered results.

Parameters:
- XLEN, 64, data width of results and write port.
- DEPTH, 4, slow-path FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result valid this cycle; no backpressure.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- slow_valid  in  1  slow-path result valid.
- slow_ready  out  1  slow-path result accepted when slow_valid and slow_ready are both high.
- slow_rd  in  5  slow-path destination register.
- slow_data  in  XLEN  slow-path result.
- query_rs1  in  5  decode source 1 for hazard lookup.
- query_rs2  in  5  decode source 2 for hazard lookup.
- hit1  out  1  query_rs1 matches a pending write.
- hit2  out  1  query_rs2 matches a pending write.
- reg_write  out  1  register-file write enable.
- rd  out  5  register-file write address.
- write_data  out  XLEN  register-file write data.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (reset_n low, asynchronous):
  - reg_write=0, rd=0, write_data=0;
  - FIFO empty, pointers=0, fifo_count=0.
  - Any in-flight FIFO content is discarded. Reset mid-operation loses buffered results by design; the pipeline is flushed alongside.
- slow_ready = (fifo_count < DEPTH). It is combinational from registered count only and does not account for a same-cycle pop.
- Per-cycle selection, evaluated combinationally and registered at the edge, in priority order:
  1. ALU: alu_valid && alu_rd!=0 selects the ALU. Output next cycle: reg_write=1, rd=alu_rd, write_data=alu_data.
  2. FIFO head: otherwise, if fifo_count>0, pop the head and write it.
  3. Bypass: otherwise, if fifo_count==0 and slow_valid, write slow_rd/slow_data directly, without enqueue. The handshake completes, giving 1-cycle latency.
  4. Idle: otherwise reg_write=0; rd and write_data hold their previous values.
- Enqueue: an accepted slow handshake not consumed by bypass, with slow_rd!=0, is pushed at the tail.
  - Push and pop in the same cycle: both happen; fifo_count is unchanged.
  - FIFO order is preserved; slow results retire in acceptance order.
- x0 filtering:
  - alu_valid with alu_rd==0 is ignored, and the slot goes to the FIFO or bypass.
  - A slow result with slow_rd==0 is accepted (slow_ready honoured) and dropped; it is never enqueued or written.
  - reg_write is therefore never 1 with rd==0.
- Latency:
  - ALU: 1 cycle.
  - Slow path: 1 cycle when bypassed; otherwise 1 + cycles waiting behind the head and ALU writes.
- Hazard lookup (combinational):
  - hit1=1 iff query_rs1!=0 and query_rs1 equals either the rd of any valid FIFO entry, or rd while reg_write=1 (write not yet in the register file).
  - hit2 is the same for query_rs2.
- Ordering: issue logic guarantees that no two in-flight writes target the same rd. The arbiter does not reorder or cancel writes.
- Wrap-around:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full is fifo_count==DEPTH; empty is fifo_count==0.
- Starvation: continuous ALU traffic starves the FIFO indefinitely. This is accepted; upstream backpressure through slow_ready bounds occupancy.

Test Plan:
- Reset then idle: assert reset_n=0 mid-run with 3 FIFO entries -> immediately reg_write=0, fifo_count=0, slow_ready=1; no writes after release.
- Bypass: FIFO empty, no ALU, slow_valid with rd=5, data=0xDEAD -> next cycle reg_write=1, rd=5, write_data=0xDEAD; fifo_count stays 0.
- Priority/buffering: alu_valid held 6 cycles (rd=1..6) while slow_valid presents rd=10..14:
  - slow_ready drops after 4 accepts and fifo_count=4;
  - ALU writes appear back-to-back;
  - then rd=10,11,12,13 drain in order, then rd=14 is bypassed or enqueued.
- Full with simultaneous push/pop: FIFO full, ALU idle -> slow_ready=0 this cycle; next cycle the head is written, fifo_count=3, slow_ready=1; a push and pop in the same cycle keep count at 3.
- x0 filtering:
  - alu_valid with alu_rd=0 alongside a queued entry -> the queued entry is written that cycle;
  - slow rd=0 handshake -> accepted, fifo_count unchanged, no write.
- Hazard lookup:
  - FIFO holds rd=7, query_rs1=7 -> hit1=1;
  - query_rs2=0 -> hit2=0;
  - after rd=7 retires and reg_write drops -> hit1=0.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU path, slow-path handshake,
// hazard lookup and register-file write port.
interface wb_arbiter_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            slow_valid;
    logic            slow_ready;
    logic [4:0]      slow_rd;
    logic [XLEN-1:0] slow_data;
    logic [4:0]      query_rs1;
    logic [4:0]      query_rs2;
    logic            hit1;
    logic            hit2;
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;
    logic [CW-1:0]   fifo_count;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  slow_valid, slow_rd, slow_data,
        input  query_rs1, query_rs2,
        output slow_ready, hit1, hit2,
        output reg_write, rd, write_data, fifo_count
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output slow_valid, slow_rd, slow_data,
        output query_rs1, query_rs2,
        input  slow_ready, hit1, hit2,
        input  reg_write, rd, write_data, fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, slow results queue in a
// small FIFO or bypass it when empty; registered write port.
module wb_arbiter #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    wb_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]      rd_mem  [DEPTH];
    logic [XLEN-1:0] dat_mem [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            accept;
    logic            alu_sel;
    logic            fifo_sel;
    logic            byp_sel;
    logic            push;
    logic            pop;
    logic            h1;
    logic            h2;
    logic [AW-1:0]   idx;

    assign bus.slow_ready = (count_q < CW'(DEPTH));
    assign bus.reg_write  = reg_write_q;
    assign bus.rd         = rd_q;
    assign bus.write_data = wdata_q;
    assign bus.fifo_count = count_q;

    // Pick the write source by priority and update FIFO bookkeeping.
    always_comb begin
        accept   = bus.slow_valid && bus.slow_ready;
        alu_sel  = bus.alu_valid && (bus.alu_rd != 5'd0);
        fifo_sel = !alu_sel && (count_q != '0);
        byp_sel  = !alu_sel && (count_q == '0) && bus.slow_valid
                   && (bus.slow_rd != 5'd0);
        pop      = fifo_sel;
        push     = accept && (bus.slow_rd != 5'd0) && !byp_sel;

        reg_write_d = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        unique case (1'b1)
            alu_sel: begin
                reg_write_d = 1'b1;
                rd_d        = bus.alu_rd;
                wdata_d     = bus.alu_data;
            end
            fifo_sel: begin
                reg_write_d = 1'b1;
                rd_d        = rd_mem[rd_ptr_q];
                wdata_d     = dat_mem[rd_ptr_q];
            end
            byp_sel: begin
                reg_write_d = 1'b1;
                rd_d        = bus.slow_rd;
                wdata_d     = bus.slow_data;
            end
            default: ;
        endcase

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Match decode sources against queued and in-flight destinations.
    always_comb begin
        h1  = reg_write_q && (rd_q == bus.query_rs1);
        h2  = reg_write_q && (rd_q == bus.query_rs2);
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (CW'(i) < count_q) begin
                if (rd_mem[idx] == bus.query_rs1) h1 = 1'b1;
                if (rd_mem[idx] == bus.query_rs2) h2 = 1'b1;
            end
        end
        bus.hit1 = h1 && (bus.query_rs1 != 5'd0);
        bus.hit2 = h2 && (bus.query_rs2 != 5'd0);
    end

    // Control state and registered write port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            wdata_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
        end
    end

    // FIFO storage; contents only matter below count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]  <= bus.slow_rd;
            dat_mem[wr_ptr_q] <= bus.slow_data;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus random
// traffic checked against a queue-based model.
module tb_wb_arbiter;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    ent_t        mq[$];
    logic        exp_we = 1'b0;
    logic [4:0]  exp_rd = 5'd0;
    logic [63:0] exp_wd = '0;
    logic [4:0]  wlog[$];
    logic        last_acc = 1'b0;

    task automatic drive(input logic av, input logic [4:0] ard,
                         input logic [63:0] ad, input logic sv,
                         input logic [4:0] srd, input logic [63:0] sd);
        bus.alu_valid  = av;
        bus.alu_rd     = ard;
        bus.alu_data   = ad;
        bus.slow_valid = sv;
        bus.slow_rd    = srd;
        bus.slow_data  = sd;
        #1;
    endtask

    task automatic query(input logic [4:0] q1, input logic [4:0] q2);
        bus.query_rs1 = q1;
        bus.query_rs2 = q2;
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_we = 1'b0;
        exp_rd = 5'd0;
        exp_wd = '0;
    endtask

    // Advance one clock; model follows the priority rules directly.
    task automatic tick();
        logic        acc;
        logic        byp;
        logic        we;
        logic [4:0]  r;
        logic [63:0] d;
        ent_t        e;
        acc = bus.slow_valid && (mq.size() < DEPTH);
        byp = 1'b0;
        we  = 1'b1;
        r   = exp_rd;
        d   = exp_wd;
        if (bus.alu_valid && bus.alu_rd != 5'd0) begin
            r = bus.alu_rd;
            d = bus.alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            r = e.rd;
            d = e.d;
        end else if (bus.slow_valid && bus.slow_rd != 5'd0) begin
            r   = bus.slow_rd;
            d   = bus.slow_data;
            byp = 1'b1;
        end else begin
            we = 1'b0;
        end
        if (acc && bus.slow_rd != 5'd0 && !byp)
            mq.push_back('{bus.slow_rd, bus.slow_data});
        last_acc = acc;
        @(posedge clk);
        #1;
        exp_we = we;
        exp_rd = r;
        exp_wd = d;
        if (we) wlog.push_back(r);
    endtask

    function automatic logic m_hit(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        if (exp_we && exp_rd == q) return 1'b1;
        foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        query(0, 0);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.reg_write, bus.rd, bus.write_data, bus.fifo_count,
             bus.slow_ready} !== {1'b0, 5'd0, 64'd0, CW'(0), 1'b1}) begin
            bad++;
            $display("FAIL reset_state got we=%b rd=%0d wd=%h cnt=%0d rdy=%b exp 0/0/0/0/1",
                     bus.reg_write, bus.rd, bus.write_data, bus.fifo_count,
                     bus.slow_ready);
        end
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        tick();
        total++;
        if (bus.reg_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got we=%b exp 0", bus.reg_write);
        end
    endtask

    task automatic test_bypass();
        drive(0, 0, 0, 1, 5'd5, 64'hDEAD);
        total++;
        if (bus.slow_ready !== 1'b1) begin
            bad++;
            $display("FAIL bypass_ready got %b exp 1", bus.slow_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        total++;
        if ({bus.reg_write, bus.rd, bus.write_data} !==
            {1'b1, 5'd5, 64'hDEAD}) begin
            bad++;
            $display("FAIL bypass_write got we=%b rd=%0d wd=%h exp 1/5/dead",
                     bus.reg_write, bus.rd, bus.write_data);
        end
        total++;
        if (bus.fifo_count !== CW'(0)) begin
            bad++;
            $display("FAIL bypass_count got %0d exp 0", bus.fifo_count);
        end
        tick();
        total++;
        if ({bus.reg_write, bus.rd, bus.write_data} !==
            {1'b0, 5'd5, 64'hDEAD}) begin
            bad++;
            $display("FAIL bypass_hold got we=%b rd=%0d wd=%h exp 0/5/dead",
                     bus.reg_write, bus.rd, bus.write_data);
        end
    endtask

    task automatic test_priority();
        int         sidx;
        logic [4:0] exp_seq[$];
        sidx = 0;
        wlog.delete();
        for (int c = 0; c < 14; c++) begin
            drive(c < 6, 5'(c + 1), 64'(c + 100), sidx < 5,
                  5'(10 + sidx), 64'(sidx + 200));
            if (c == 4) begin
                total++;
                if ({bus.slow_ready, bus.fifo_count} !== {1'b0, CW'(4)}) begin
                    bad++;
                    $display("FAIL prio_full got rdy=%b cnt=%0d exp 0/4",
                             bus.slow_ready, bus.fifo_count);
                end
            end
            tick();
            if (bus.slow_valid && last_acc) sidx++;
            total++;
            if ({bus.reg_write, bus.rd, bus.write_data, bus.fifo_count} !==
                {exp_we, exp_rd, exp_wd, CW'(mq.size())}) begin
                bad++;
                $display("FAIL prio_cycle%0d got we=%b rd=%0d wd=%h cnt=%0d exp %b/%0d/%h/%0d",
                         c, bus.reg_write, bus.rd, bus.write_data,
                         bus.fifo_count, exp_we, exp_rd, exp_wd, mq.size());
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) exp_seq.push_back(5'(i));
        for (int i = 10; i <= 14; i++) exp_seq.push_back(5'(i));
        total++;
        if (wlog != exp_seq) begin
            bad++;
            $display("FAIL prio_order got %p exp %p", wlog, exp_seq);
        end
    endtask

    task automatic test_full();
        logic [4:0] tail[3];
        tail[0] = 5'd22;
        tail[1] = 5'd23;
        tail[2] = 5'd24;
        for (int c = 0; c < 4; c++) begin
            drive(1, 5'(c + 1), 64'(c), 1, 5'(20 + c), 64'(c + 20));
            tick();
        end
        drive(0, 0, 0, 1, 5'd24, 64'h24);
        total++;
        if ({bus.slow_ready, bus.fifo_count} !== {1'b0, CW'(4)}) begin
            bad++;
            $display("FAIL full_ready got rdy=%b cnt=%0d exp 0/4",
                     bus.slow_ready, bus.fifo_count);
        end
        tick();
        total++;
        if ({bus.reg_write, bus.rd, bus.fifo_count, bus.slow_ready} !==
            {1'b1, 5'd20, CW'(3), 1'b1}) begin
            bad++;
            $display("FAIL full_pop got we=%b rd=%0d cnt=%0d rdy=%b exp 1/20/3/1",
                     bus.reg_write, bus.rd, bus.fifo_count, bus.slow_ready);
        end
        tick();
        total++;
        if ({bus.reg_write, bus.rd, bus.fifo_count} !==
            {1'b1, 5'd21, CW'(3)}) begin
            bad++;
            $display("FAIL full_pushpop got we=%b rd=%0d cnt=%0d exp 1/21/3",
                     bus.reg_write, bus.rd, bus.fifo_count);
        end
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({bus.reg_write, bus.rd} !== {1'b1, tail[i]}) begin
                bad++;
                $display("FAIL full_drain%0d got we=%b rd=%0d exp 1/%0d",
                         i, bus.reg_write, bus.rd, tail[i]);
            end
        end
        tick();
        total++;
        if ({bus.reg_write, bus.fifo_count} !== {1'b0, CW'(0)}) begin
            bad++;
            $display("FAIL full_empty got we=%b cnt=%0d exp 0/0",
                     bus.reg_write, bus.fifo_count);
        end
    endtask

    task automatic test_x0();
        drive(1, 5'd1, 64'h11, 1, 5'd30, 64'h30);
        tick();
        drive(1, 5'd0, 64'h99, 0, 0, 0);
        tick();
        total++;
        if ({bus.reg_write, bus.rd, bus.write_data, bus.fifo_count} !==
            {1'b1, 5'd30, 64'h30, CW'(0)}) begin
            bad++;
            $display("FAIL x0_alu got we=%b rd=%0d wd=%h cnt=%0d exp 1/30/30/0",
                     bus.reg_write, bus.rd, bus.write_data, bus.fifo_count);
        end
        drive(1, 5'd2, 64'h22, 1, 5'd31, 64'h31);
        tick();
        drive(1, 5'd3, 64'h33, 1, 5'd0, 64'hBAD);
        total++;
        if (bus.slow_ready !== 1'b1) begin
            bad++;
            $display("FAIL x0_ready got %b exp 1", bus.slow_ready);
        end
        tick();
        total++;
        if ({bus.rd, bus.fifo_count} !== {5'd3, CW'(1)}) begin
            bad++;
            $display("FAIL x0_slow_queued got rd=%0d cnt=%0d exp 3/1",
                     bus.rd, bus.fifo_count);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 5'd0, 64'hBAD);
        tick();
        total++;
        if ({bus.reg_write, bus.fifo_count} !== {1'b0, CW'(0)}) begin
            bad++;
            $display("FAIL x0_slow_drop got we=%b cnt=%0d exp 0/0",
                     bus.reg_write, bus.fifo_count);
        end
    endtask

    task automatic test_hazard();
        query(5'd7, 5'd0);
        drive(1, 5'd1, 64'h1, 1, 5'd7, 64'h77);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        total++;
        if ({bus.hit1, bus.hit2} !== 2'b10) begin
            bad++;
            $display("FAIL hazard_queued got h1=%b h2=%b exp 1/0",
                     bus.hit1, bus.hit2);
        end
        tick();
        total++;
        if ({bus.reg_write, bus.rd, bus.hit1} !== {1'b1, 5'd7, 1'b1}) begin
            bad++;
            $display("FAIL hazard_inflight got we=%b rd=%0d h1=%b exp 1/7/1",
                     bus.reg_write, bus.rd, bus.hit1);
        end
        tick();
        total++;
        if (bus.hit1 !== 1'b0) begin
            bad++;
            $display("FAIL hazard_retired got h1=%b exp 0", bus.hit1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
                  {$urandom, $urandom}, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), {$urandom, $urandom});
            query(5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
            total++;
            if ({bus.slow_ready, bus.hit1, bus.hit2} !==
                {mq.size() < DEPTH, m_hit(bus.query_rs1),
                 m_hit(bus.query_rs2)}) begin
                bad++;
                $display("FAIL rand_comb%0d got rdy=%b h1=%b h2=%b exp %b/%b/%b",
                         c, bus.slow_ready, bus.hit1, bus.hit2,
                         mq.size() < DEPTH, m_hit(bus.query_rs1),
                         m_hit(bus.query_rs2));
            end
            tick();
            total++;
            if ({bus.reg_write, bus.rd, bus.write_data, bus.fifo_count} !==
                {exp_we, exp_rd, exp_wd, CW'(mq.size())}) begin
                bad++;
                $display("FAIL rand_reg%0d got we=%b rd=%0d wd=%h cnt=%0d exp %b/%0d/%h/%0d",
                         c, bus.reg_write, bus.rd, bus.write_data,
                         bus.fifo_count, exp_we, exp_rd, exp_wd, mq.size());
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        query(0, 0);
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'(c + 1), 64'(c), 1, 5'(c + 12), 64'(c + 12));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        total++;
        if (bus.fifo_count !== CW'(3)) begin
            bad++;
            $display("FAIL rstmid_fill got cnt=%0d exp 3", bus.fifo_count);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({bus.reg_write, bus.fifo_count, bus.slow_ready} !==
            {1'b0, CW'(0), 1'b1}) begin
            bad++;
            $display("FAIL rstmid_async got we=%b cnt=%0d rdy=%b exp 0/0/1",
                     bus.reg_write, bus.fifo_count, bus.slow_ready);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({bus.reg_write, bus.fifo_count} !== {1'b0, CW'(0)}) begin
                bad++;
                $display("FAIL rstmid_after%0d got we=%b cnt=%0d exp 0/0",
                         i, bus.reg_write, bus.fifo_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_priority();
        test_full();
        test_x0();
        test_hazard();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
